pc_sched: RTL and testbench

- Next-PC scheduler for the fetch stage; sole driver of the program-counter register's jump_addr/jump_en inputs.
- Arbitrates between three requesters:
  - trap redirect;
  - execute-stage jump/branch;
  - hold requests from the hazard unit and the instruction-fetch bus.
- Implements a PC stall by re-loading the current PC through the jump path.
- Generates the IF/ID flush and the fetch-valid qualifier, and keeps redirect/stall performance counters.

---
 rtl/pc_sched.sv | 118 +++++++++++
 tb/tb_pc_sched.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_sched.sv
// Next-PC scheduler: picks the PC load value from trap, execute jump or stall each cycle.
// Decisions are combinational from state and inputs; the state and counters are registered.
module pc_sched #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_addr_i,
  input  logic             trap_en_i,
  input  logic [31:0]      trap_addr_i,
  input  logic             ex_jump_en_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             hold_i,
  input  logic             ifetch_ready_i,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             flush_o,
  output logic             fetch_valid_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      pend_addr;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic        redir;
  logic [31:0] tgt;
  logic        redirect_inc;
  logic        stall_inc;

  assign redir = trap_en_i | ex_jump_en_i;
  assign tgt   = trap_en_i ? trap_addr_i : ex_jump_addr_i;

  // A stall is realised by re-loading the current PC through the jump path.
  always_comb begin
    jump_en_o     = 1'b1;
    jump_addr_o   = pc_addr_i;
    flush_o       = 1'b0;
    fetch_valid_o = 1'b0;
    redirect_inc  = 1'b0;
    stall_inc     = 1'b0;
    case (state)
      RUN: begin
        if (redir) begin
          jump_addr_o  = ifetch_ready_i ? tgt : pc_addr_i;
          flush_o      = 1'b1;
          redirect_inc = 1'b1;
        end else if (hold_i || !ifetch_ready_i) begin
          stall_inc = 1'b1;
        end else begin
          jump_en_o     = 1'b0;
          fetch_valid_o = 1'b1;
        end
      end
      PEND: begin
        flush_o      = 1'b1;
        redirect_inc = redir;
        if (ifetch_ready_i) begin
          jump_addr_o = redir ? tgt : pend_addr;
        end else begin
          stall_inc = 1'b1;
        end
      end
      default: begin
        jump_addr_o = BOOT_ADDR;
        flush_o     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pend_addr <= 32'h0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (redir && !ifetch_ready_i) begin
            state     <= PEND;
            pend_addr <= tgt;
          end
        end
        PEND: begin
          // A newer redirect replaces the parked target.
          if (redir) pend_addr <= tgt;
          if (ifetch_ready_i) state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (redirect_inc && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 1'b1;
      if (stall_inc && (stall_cnt != '1))       stall_cnt    <= stall_cnt + 1'b1;
    end
  end

  assign state_o        = state;
  assign redirect_cnt_o = redirect_cnt;
  assign stall_cnt_o    = stall_cnt;

endmodule

// File: tb/tb_pc_sched.sv
// Directed vector bench for pc_sched with a behavioural PC register closing the loop.
module tb_pc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        trap_en, ex_en, hold, rdy;
  logic [31:0] trap_addr, ex_addr;
  logic        jump_en, flush, fetch_valid;
  logic [31:0] jump_addr;
  logic [1:0]  state;
  logic [15:0] redirect_cnt, stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sched #(.BOOT_ADDR(32'h100), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_addr_i(pc),
    .trap_en_i(trap_en), .trap_addr_i(trap_addr),
    .ex_jump_en_i(ex_en), .ex_jump_addr_i(ex_addr),
    .hold_i(hold), .ifetch_ready_i(rdy),
    .jump_en_o(jump_en), .jump_addr_o(jump_addr), .flush_o(flush),
    .fetch_valid_o(fetch_valid), .state_o(state),
    .redirect_cnt_o(redirect_cnt), .stall_cnt_o(stall_cnt)
  );

  // Program-counter register: loads jump_addr or steps by 4.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= 32'h0;
    else     pc <= jump_en ? jump_addr : pc + 32'd4;
  end

  typedef struct {
    logic        trap; logic [31:0] taddr;
    logic        ex;   logic [31:0] eaddr;
    logic        hold; logic        rdy;
    logic [31:0] pc;   logic [1:0]  st;
    logic        je;   logic [31:0] ja;
    logic        fl;   logic        fv;
    logic [15:0] rc;   logic [15:0] sc;
  } vec_t;

  function automatic vec_t mk(input logic t, input logic [31:0] ta, input logic e,
                              input logic [31:0] ea, input logic h, input logic r,
                              input logic [31:0] p, input logic [1:0] s, input logic j,
                              input logic [31:0] a, input logic f, input logic v,
                              input logic [15:0] rc, input logic [15:0] sc);
    vec_t x;
    x.trap = t; x.taddr = ta; x.ex = e; x.eaddr = ea; x.hold = h; x.rdy = r;
    x.pc = p; x.st = s; x.je = j; x.ja = a; x.fl = f; x.fv = v; x.rc = rc; x.sc = sc;
    return x;
  endfunction

  localparam int N = 26;
  vec_t tbl[N];
  vec_t post[3];

  task automatic check(input string name, input logic ok, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Drive one vector, then compare everything it expects while clk is low.
  task automatic apply(input vec_t v, input string tag, input int idx);
    logic ok;
    trap_en = v.trap; trap_addr = v.taddr; ex_en = v.ex; ex_addr = v.eaddr;
    hold = v.hold; rdy = v.rdy;
    #1;
    ok = (pc === v.pc) && (state === v.st) && (jump_en === v.je) &&
         (!v.je || jump_addr === v.ja) && (flush === v.fl) &&
         (fetch_valid === v.fv) && (redirect_cnt === v.rc) && (stall_cnt === v.sc);
    total++;
    if (ok) passed++;
    else $display("FAIL %s[%0d]: actual pc=%h st=%0d je=%b ja=%h fl=%b fv=%b rc=%0d sc=%0d required pc=%h st=%0d je=%b ja=%h fl=%b fv=%b rc=%0d sc=%0d",
                  tag, idx, pc, state, jump_en, jump_addr, flush, fetch_valid, redirect_cnt,
                  stall_cnt, v.pc, v.st, v.je, v.ja, v.fl, v.fv, v.rc, v.sc);
  endtask

  initial begin
    //             trap taddr  ex eaddr  h  r  pc       st je ja       fl fv rc sc
    tbl[0]  = mk(0, 0,     0, 0,     0, 1, 32'h000, 0, 1, 32'h100, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0,     0, 0,     0, 1, 32'h100, 1, 0, 0,       0, 1, 0, 0);
    tbl[2]  = mk(0, 0,     0, 0,     0, 1, 32'h104, 1, 0, 0,       0, 1, 0, 0);
    tbl[3]  = mk(0, 0,     0, 0,     0, 1, 32'h108, 1, 0, 0,       0, 1, 0, 0);
    tbl[4]  = mk(0, 0,     1, 32'h200, 0, 1, 32'h10C, 1, 1, 32'h200, 1, 0, 0, 0);
    tbl[5]  = mk(1, 32'h80, 1, 32'h400, 0, 1, 32'h200, 1, 1, 32'h080, 1, 0, 1, 0);
    tbl[6]  = mk(0, 0,     0, 0,     0, 1, 32'h080, 1, 0, 0,       0, 1, 2, 0);
    tbl[7]  = mk(0, 0,     1, 32'h300, 0, 1, 32'h084, 1, 1, 32'h300, 1, 0, 2, 0);
    tbl[8]  = mk(0, 0,     0, 0,     1, 1, 32'h300, 1, 1, 32'h300, 0, 0, 3, 0);
    tbl[9]  = mk(0, 0,     0, 0,     1, 1, 32'h300, 1, 1, 32'h300, 0, 0, 3, 1);
    tbl[10] = mk(0, 0,     0, 0,     1, 1, 32'h300, 1, 1, 32'h300, 0, 0, 3, 2);
    tbl[11] = mk(0, 0,     0, 0,     0, 1, 32'h300, 1, 0, 0,       0, 1, 3, 3);
    tbl[12] = mk(0, 0,     0, 0,     0, 1, 32'h304, 1, 0, 0,       0, 1, 3, 3);
    tbl[13] = mk(0, 0,     1, 32'h340, 1, 1, 32'h308, 1, 1, 32'h340, 1, 0, 3, 3);
    tbl[14] = mk(0, 0,     0, 0,     0, 0, 32'h340, 1, 1, 32'h340, 0, 0, 4, 3);
    tbl[15] = mk(0, 0,     1, 32'h500, 0, 0, 32'h340, 1, 1, 32'h340, 1, 0, 4, 4);
    tbl[16] = mk(0, 0,     0, 0,     0, 0, 32'h340, 2, 1, 32'h340, 1, 0, 5, 4);
    tbl[17] = mk(0, 0,     0, 0,     1, 1, 32'h340, 2, 1, 32'h500, 1, 0, 5, 5);
    tbl[18] = mk(0, 0,     0, 0,     0, 1, 32'h500, 1, 0, 0,       0, 1, 5, 5);
    tbl[19] = mk(0, 0,     1, 32'h600, 0, 0, 32'h504, 1, 1, 32'h504, 1, 0, 5, 5);
    tbl[20] = mk(1, 32'h80, 0, 0,     0, 0, 32'h504, 2, 1, 32'h504, 1, 0, 6, 5);
    tbl[21] = mk(0, 0,     0, 0,     0, 1, 32'h504, 2, 1, 32'h080, 1, 0, 7, 6);
    tbl[22] = mk(0, 0,     0, 0,     0, 1, 32'h080, 1, 0, 0,       0, 1, 7, 6);
    tbl[23] = mk(0, 0,     1, 32'h700, 0, 0, 32'h084, 1, 1, 32'h084, 1, 0, 7, 6);
    tbl[24] = mk(0, 0,     1, 32'h900, 0, 1, 32'h084, 2, 1, 32'h900, 1, 0, 8, 6);
    tbl[25] = mk(0, 0,     0, 0,     0, 1, 32'h900, 1, 0, 0,       0, 1, 9, 6);
    // After reset out of PEND the parked target A00 must never appear.
    post[0] = mk(0, 0,     0, 0,     0, 1, 32'h000, 0, 1, 32'h100, 1, 0, 0, 0);
    post[1] = mk(0, 0,     0, 0,     0, 1, 32'h100, 1, 0, 0,       0, 1, 0, 0);
    post[2] = mk(0, 0,     0, 0,     0, 1, 32'h104, 1, 0, 0,       0, 1, 0, 0);

    rst = 1'b1;
    trap_en = 0; ex_en = 0; hold = 0; rdy = 1; trap_addr = 0; ex_addr = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_jump_en", jump_en === 1'b1, {31'b0, jump_en}, 32'h1);
    check("reset_jump_addr", jump_addr === 32'h100, jump_addr, 32'h100);
    check("reset_flush_fv", flush === 1'b1 && fetch_valid === 1'b0, {30'b0, flush, fetch_valid}, 32'h2);
    check("reset_state_cnt", state === 2'd0 && redirect_cnt === 16'd0 && stall_cnt === 16'd0,
          {state, redirect_cnt[7:0], stall_cnt[7:0]}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      apply(tbl[i], "vec", i);
    end

    // Stall saturation: walk stall_cnt from 6 to FFFE, then three more stalls.
    @(negedge clk);
    trap_en = 0; ex_en = 0; rdy = 1; hold = 1;
    repeat (16'hFFFE - 6) @(negedge clk);
    #1;
    check("stall_cnt_fffe", stall_cnt === 16'hFFFE, {16'b0, stall_cnt}, 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_cnt_sat", stall_cnt === 16'hFFFF && pc === 32'h904,
            {stall_cnt, pc[15:0]}, 32'hFFFF_0904);
    end
    check("redirect_cnt_kept", redirect_cnt === 16'd9, {16'b0, redirect_cnt}, 32'd9);

    // Enter PEND, then assert reset between clock edges.
    @(negedge clk);
    hold = 0; ex_en = 1; ex_addr = 32'hA00; rdy = 0;
    @(negedge clk);
    ex_en = 0;
    #1;
    check("pend_entered", state === 2'd2 && jump_addr === 32'h904, {state, jump_addr[29:0]}, {2'd2, 30'h904});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", state === 2'd0 && jump_addr === 32'h100, {state, jump_addr[29:0]}, {2'd0, 30'h100});
    check("async_rst_pend_addr", dut.pend_addr === 32'h0, dut.pend_addr, 32'h0);
    check("async_rst_cnt", redirect_cnt === 16'd0 && stall_cnt === 16'd0, {redirect_cnt, stall_cnt}, 32'h0);
    rdy = 1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      apply(post[i], "post_rst", i);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
